// File: rtl/ac_exec_unit_if.sv
// Request handshake bundle between the core controller and ac_exec_unit.
// master: controller side (drives the request). slave: execution unit side.
interface ac_exec_unit_if #(
   parameter int DW  = 16,
   parameter int OPW = 3
);
   logic           req_valid;
   logic           req_ready;
   logic [OPW-1:0] req_op;
   logic [DW-1:0]  req_operand;

   modport master (
      output req_valid,
      output req_op,
      output req_operand,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_operand,
      output req_ready
   );
endinterface

// File: rtl/ac_exec_unit.sv
// Accumulator / sequencer stage around the combinational alu of a matmul core.
// One request per handshake: IDLE -> EXEC (alu driven) -> WB (done pulse).
// Optional feature macro: AC_ZFLAG_EN (registered zero flag on every AC write).
module ac_exec_unit #(
   parameter int DW  = 16,
   parameter int OPW = 3
) (
   input  logic            clk,
   input  logic            rstn,
   ac_exec_unit_if.slave   req,
   input  logic            ac_load,
   input  logic [DW-1:0]   ac_load_data,
   output logic [DW-1:0]   alu_in_bus,
   output logic [DW-1:0]   alu_in_ac,
   output logic [OPW-1:0]  alu_operation,
   input  logic [DW-1:0]   alu_data_out,
   output logic [DW-1:0]   ac_out,
   output logic            done,
   output logic            busy,
   output logic            z_flag
);

   localparam logic [OPW-1:0] OP_CLR = OPW'(6);
   localparam logic [OPW-1:0] OP_INC = OPW'(7);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t          state;
   logic [DW-1:0]   ac;
   logic [OPW-1:0]  op_q;
   logic [DW-1:0]   opd_q;
   logic            ac_wr_en;
   logic [DW-1:0]   ac_wr_data;

   // alu operands come straight from the latched request; AC feeds back as in_AC
   assign alu_in_bus    = opd_q;
   assign alu_operation = op_q;
   assign alu_in_ac     = ac;
   assign ac_out        = ac;

   // Ready only in IDLE and only when no direct load competes for AC
   always_comb begin
      req.req_ready = (state == IDLE) && !ac_load;
   end

   // Select the AC write source: direct load in IDLE or op commit at end of EXEC
   always_comb begin
      ac_wr_en   = 1'b0;
      ac_wr_data = ac;
      if (state == IDLE && ac_load) begin
         ac_wr_en   = 1'b1;
         ac_wr_data = ac_load_data;
      end else if (state == EXEC) begin
         ac_wr_en = 1'b1;
         if (op_q == OP_CLR)
            ac_wr_data = '0;
         else if (op_q == OP_INC)
            ac_wr_data = ac + DW'(1);
         else
            ac_wr_data = alu_data_out;
      end
   end

   // Sequencer FSM with registered done/busy and the accumulator register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         ac    <= '0;
         op_q  <= '0;
         opd_q <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         if (ac_wr_en)
            ac <= ac_wr_data;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (req.req_valid && !ac_load) begin
                  op_q  <= req.req_op;
                  opd_q <= req.req_operand;
                  state <= EXEC;
                  busy  <= 1'b1;
               end
            end
            EXEC: begin
               state <= WB;
               done  <= 1'b1;
            end
            WB: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AC_ZFLAG_EN
   // Zero flag tracks the value of every AC write
   always_ff @(posedge clk) begin
      if (!rstn)
         z_flag <= 1'b0;
      else if (ac_wr_en)
         z_flag <= (ac_wr_data == '0);
   end
`else
   assign z_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ac_exec_unit.sv
// Self-checking bench for ac_exec_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a timing-level model.
module tb_ac_exec_unit;

   localparam int DW  = 16;
   localparam int OPW = 3;

   logic            clk;
   logic            rstn;
   logic            ac_load;
   logic [DW-1:0]   ac_load_data;
   logic [DW-1:0]   alu_in_bus;
   logic [DW-1:0]   alu_in_ac;
   logic [OPW-1:0]  alu_operation;
   logic [DW-1:0]   alu_data_out;
   logic [DW-1:0]   ac_out;
   logic            done;
   logic            busy;
   logic            z_flag;

   int checks = 0;
   int errors = 0;

   ac_exec_unit_if #(.DW(DW), .OPW(OPW)) req_if ();

   ac_exec_unit #(.DW(DW), .OPW(OPW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req           (req_if.slave),
      .ac_load       (ac_load),
      .ac_load_data  (ac_load_data),
      .alu_in_bus    (alu_in_bus),
      .alu_in_ac     (alu_in_ac),
      .alu_operation (alu_operation),
      .alu_data_out  (alu_data_out),
      .ac_out        (ac_out),
      .done          (done),
      .busy          (busy),
      .z_flag        (z_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_z(input logic [DW-1:0] v);
`ifdef AC_ZFLAG_EN
      return (v == '0);
`else
      return 1'b0;
`endif
   endfunction

   typedef struct {
      logic [DW-1:0]  load_data;
      logic [OPW-1:0] op;
      logic [DW-1:0]  operand;
      logic [DW-1:0]  alu_val;
      logic [DW-1:0]  exp_ac;
   } vec_t;

   vec_t vecs [8];

   // random-run model
   int              e;
   int              last_acc;
   logic            idle_m;
   logic [DW-1:0]   m_ac;
   logic            m_z;
   logic [OPW-1:0]  m_op;
   logic [DW-1:0]   m_opd;
   int              accepts;

   initial begin
      vecs[0] = '{16'd5,    3'd3, 16'd2,    16'h00AB, 16'h00AB};
      vecs[1] = '{16'hFFFF, 3'd7, 16'h0000, 16'h1234, 16'h0000};
      vecs[2] = '{16'h1234, 3'd6, 16'h0055, 16'h0077, 16'h0000};
      vecs[3] = '{16'h0000, 3'd0, 16'h0003, 16'h0000, 16'h0000};
      vecs[4] = '{16'h0010, 3'd1, 16'h0004, 16'hBEEF, 16'hBEEF};
      vecs[5] = '{16'h7FFF, 3'd7, 16'h0000, 16'h0000, 16'h8000};
      vecs[6] = '{16'h0000, 3'd2, 16'h0001, 16'hFFFF, 16'hFFFF};
      vecs[7] = '{16'hA5A5, 3'd5, 16'h0F0F, 16'h5A5A, 16'h5A5A};

      rstn              = 1'b0;
      ac_load           = 1'b0;
      ac_load_data      = '0;
      alu_data_out      = '0;
      req_if.req_valid   = 1'b1;
      req_if.req_op      = 3'd7;
      req_if.req_operand = 16'h1111;

      // reset with a pending request
      tick();
      check("rst_ac", ac_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bus", alu_in_bus, 0);
      check("rst_oper", alu_operation, 0);
      check("rst_z", z_flag, 0);
      req_if.req_valid = 1'b0;
      rstn = 1'b1;
      #1;
      check("rst_ready", req_if.req_ready, 1);
      tick();

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         ac_load      = 1'b1;
         ac_load_data = vecs[i].load_data;
         tick();
         ac_load            = 1'b0;
         req_if.req_valid   = 1'b1;
         req_if.req_op      = vecs[i].op;
         req_if.req_operand = vecs[i].operand;
         #1;
         check("vec_ready", req_if.req_ready, 1);
         check("vec_loaded", ac_out, vecs[i].load_data);
         tick();
         req_if.req_valid = 1'b0;
         alu_data_out     = vecs[i].alu_val;
         #1;
         check("vec_exec_bus", alu_in_bus, vecs[i].operand);
         check("vec_exec_op", alu_operation, vecs[i].op);
         check("vec_exec_ac", alu_in_ac, vecs[i].load_data);
         check("vec_exec_busy", busy, 1);
         check("vec_exec_done", done, 0);
         check("vec_exec_ready", req_if.req_ready, 0);
         tick();
         check("vec_wb_ac", ac_out, vecs[i].exp_ac);
         check("vec_wb_done", done, 1);
         check("vec_wb_z", z_flag, exp_z(vecs[i].exp_ac));
         tick();
         check("vec_idle_done", done, 0);
         check("vec_idle_busy", busy, 0);
         check("vec_idle_bus", alu_in_bus, vecs[i].operand);
         check("vec_idle_ac", ac_out, vecs[i].exp_ac);
      end

      // CLR with req_valid held for 5 cycles: one accept per IDLE visit
      ac_load      = 1'b1;
      ac_load_data = 16'h1234;
      tick();
      ac_load            = 1'b0;
      req_if.req_valid   = 1'b1;
      req_if.req_op      = 3'd6;
      req_if.req_operand = 16'h0;
      accepts = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (busy) check("hold_ready_busy", req_if.req_ready, 0);
         if (req_if.req_ready) accepts++;
         tick();
      end
      req_if.req_valid = 1'b0;
      check("hold_accepts", accepts, 2);
      tick();
      tick();
      check("hold_ac", ac_out, 0);
      check("hold_idle", busy, 0);

      // load conflict: load wins, request taken next cycle
      ac_load            = 1'b1;
      ac_load_data       = 16'd9;
      req_if.req_valid   = 1'b1;
      req_if.req_op      = 3'd7;
      req_if.req_operand = 16'h0;
      #1;
      check("conf_ready", req_if.req_ready, 0);
      tick();
      check("conf_ac", ac_out, 9);
      check("conf_done", done, 0);
      check("conf_busy", busy, 0);
      ac_load = 1'b0;
      #1;
      check("conf_ready2", req_if.req_ready, 1);
      tick();
      req_if.req_valid = 1'b0;
      check("conf_accepted", busy, 1);
      tick();
      check("conf_result", ac_out, 10);
      check("conf_done2", done, 1);
      tick();

      // reset during EXEC aborts the op
      ac_load      = 1'b1;
      ac_load_data = 16'd7;
      tick();
      ac_load            = 1'b0;
      req_if.req_valid   = 1'b1;
      req_if.req_op      = 3'd0;
      req_if.req_operand = 16'h0003;
      tick();
      req_if.req_valid = 1'b0;
      alu_data_out     = 16'h0055;
      check("abort_exec", busy, 1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("abort_ac", ac_out, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      tick();
      check("abort_done2", done, 0);
      check("abort_ac2", ac_out, 0);

      // randomized run against a timing-level model
      tick();
      e        = 0;
      last_acc = -10;
      m_ac     = ac_out;
      m_z      = z_flag;
      m_op     = alu_operation;
      m_opd    = alu_in_bus;
      for (int n = 0; n < 600; n++) begin
         idle_m             = (e - last_acc) >= 3;
         req_if.req_valid   = 1'($urandom_range(0, 1));
         req_if.req_op      = OPW'($urandom_range(0, 7));
         req_if.req_operand = DW'($urandom);
         ac_load            = ($urandom_range(0, 3) == 0);
         ac_load_data       = ($urandom_range(0, 5) == 0) ? 16'h0 : DW'($urandom);
         alu_data_out       = ($urandom_range(0, 5) == 0) ? 16'h0 : DW'($urandom);
         #1;
         check("rnd_ready", req_if.req_ready, idle_m && !ac_load);
         check("rnd_busy", busy, !idle_m);
         check("rnd_done", done, (e - last_acc) == 2);
         check("rnd_ac", ac_out, m_ac);
         check("rnd_in_ac", alu_in_ac, m_ac);
         check("rnd_z", z_flag, m_z);
         check("rnd_bus", alu_in_bus, m_opd);
         check("rnd_oper", alu_operation, m_op);
         @(posedge clk);
         if ((e - last_acc) == 1) begin
            if (m_op == 3'd6)      m_ac = '0;
            else if (m_op == 3'd7) m_ac = m_ac + 16'd1;
            else                   m_ac = alu_data_out;
            m_z = exp_z(m_ac);
         end else if (idle_m && ac_load) begin
            m_ac = ac_load_data;
            m_z  = exp_z(m_ac);
         end else if (idle_m && req_if.req_valid) begin
            last_acc = e;
            m_op     = req_if.req_op;
            m_opd    = req_if.req_operand;
         end
         e++;
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
